// File: rtl/timer_ahb_sequencer.sv
// AHB-Lite master that programs timer_8bit behind the AHB-to-APB bridge, then
// polls TSR for overflows and clears each one until the requested count is met.
module timer_ahb_sequencer #(
   parameter logic [31:0] BASE_ADDR = 32'hC010_0000,
   parameter logic [3:0]  OFS_TCR   = 4'h1,
   parameter logic [3:0]  OFS_TSR   = 4'h2,
   parameter logic [3:0]  OFS_MAX   = 4'h5,
   parameter logic [3:0]  OFS_MIN   = 4'h6,
   parameter int unsigned POLL_GAP  = 16,
   parameter logic [7:0]  MAX_POLLS = 8'd255
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        start,
   input  logic [7:0]  cfg_tcr,
   input  logic [7:0]  cfg_max,
   input  logic [7:0]  cfg_min,
   input  logic [7:0]  ovf_target,
   output logic        HSEL,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [31:0] HWDATA,
   output logic        HREADYIN,
   input  logic        HREADYOUT,
   input  logic [7:0]  HRDATA,
   input  logic        HRESP,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic [7:0]  ovf_cnt,
   output logic [7:0]  last_tsr,
   output logic [2:0]  dbg_state_o
);

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_GAP, S_DONE, S_ERR} state_t;
   typedef enum logic [2:0] {OP_W_TCR, OP_W_MAX, OP_W_MIN, OP_R_TSR, OP_W_CLR} op_t;

   localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

   state_t           state_q, state_d;
   op_t              op_q, op_d;
   logic [7:0]       tcr_q, tcr_d, max_q, max_d, min_q, min_d, tgt_q, tgt_d;
   logic [7:0]       ovf_q, ovf_d, poll_q, poll_d, last_q, last_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             error_q, error_d;
   logic [1:0]       code_q, code_d;
   logic [3:0]       ofs;
   logic [7:0]       wbyte;
   logic             on_bus;

   // Handshake: ADDR holds NONSEQ and the address until an edge with HREADYOUT=1;
   // DATA then waits for the next such edge, where HRESP/HRDATA are sampled.
   always_comb begin
      ofs   = OFS_TSR;
      wbyte = 8'h00;
      case (op_q)
         OP_W_TCR: begin ofs = OFS_TCR; wbyte = tcr_q; end
         OP_W_MAX: begin ofs = OFS_MAX; wbyte = max_q; end
         OP_W_MIN: begin ofs = OFS_MIN; wbyte = min_q; end
         default:  ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      tcr_d   = tcr_q;
      max_d   = max_q;
      min_d   = min_q;
      tgt_d   = tgt_q;
      ovf_d   = ovf_q;
      poll_d  = poll_q;
      last_d  = last_q;
      gap_d   = '0;
      error_d = error_q;
      code_d  = code_q;
      case (state_q)
         S_IDLE: if (start) begin
            tcr_d   = cfg_tcr;
            max_d   = cfg_max;
            min_d   = cfg_min;
            tgt_d   = ovf_target;
            ovf_d   = 8'h00;
            poll_d  = 8'h00;
            error_d = 1'b0;
            code_d  = 2'd0;
            op_d    = OP_W_TCR;
            state_d = S_ADDR;
         end
         S_ADDR: if (HREADYOUT) state_d = S_DATA;
         S_DATA: if (HREADYOUT) begin
            if (HRESP) begin
               state_d = S_ERR;
               error_d = 1'b1;
               code_d  = 2'd1;
            end else begin
               case (op_q)
                  OP_W_TCR: begin op_d = OP_W_MAX; state_d = S_ADDR; end
                  OP_W_MAX: begin op_d = OP_W_MIN; state_d = S_ADDR; end
                  OP_W_MIN: state_d = (tgt_q == 8'h00) ? S_DONE : S_GAP;
                  OP_R_TSR: begin
                     last_d = HRDATA;
                     if (HRDATA[0]) begin
                        op_d    = OP_W_CLR;
                        poll_d  = 8'h00;
                        state_d = S_ADDR;
                     end else begin
                        poll_d = poll_q + 8'd1;
                        if (poll_q + 8'd1 == MAX_POLLS) begin
                           state_d = S_ERR;
                           error_d = 1'b1;
                           code_d  = 2'd2;
                        end else begin
                           state_d = S_GAP;
                        end
                     end
                  end
                  OP_W_CLR: begin
                     ovf_d   = ovf_q + 8'd1;
                     state_d = (ovf_q + 8'd1 == tgt_q) ? S_DONE : S_GAP;
                  end
                  default: state_d = S_IDLE;
               endcase
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               op_d    = OP_R_TSR;
               state_d = S_ADDR;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= S_IDLE;
         op_q    <= OP_W_TCR;
         tcr_q   <= 8'h00;
         max_q   <= 8'h00;
         min_q   <= 8'h00;
         tgt_q   <= 8'h00;
         ovf_q   <= 8'h00;
         poll_q  <= 8'h00;
         last_q  <= 8'h00;
         gap_q   <= '0;
         error_q <= 1'b0;
         code_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         tcr_q   <= tcr_d;
         max_q   <= max_d;
         min_q   <= min_d;
         tgt_q   <= tgt_d;
         ovf_q   <= ovf_d;
         poll_q  <= poll_d;
         last_q  <= last_d;
         gap_q   <= gap_d;
         error_q <= error_d;
         code_q  <= code_d;
      end
   end

   assign on_bus      = (state_q == S_ADDR) || (state_q == S_DATA);
   assign HSEL        = on_bus;
   assign HADDR       = on_bus ? (BASE_ADDR + {28'h0, ofs}) : 32'h0;
   assign HTRANS      = (state_q == S_ADDR) ? 2'b10 : 2'b00;
   assign HWRITE      = on_bus && (op_q != OP_R_TSR);
   assign HWDATA      = ((state_q == S_DATA) && (op_q != OP_R_TSR)) ? {24'h0, wbyte} : 32'h0;
   assign HSIZE       = 3'b010;
   assign HREADYIN    = 1'b1;
   assign busy        = on_bus || (state_q == S_GAP);
   assign done        = (state_q == S_DONE);
   assign error       = error_q;
   assign err_code    = code_q;
   assign ovf_cnt     = ovf_q;
   assign last_tsr    = last_q;
   assign dbg_state_o = state_q;

endmodule
